// File: rtl/tdm_voice_engine_if.sv
// Config handshake from the MIDI control unit plus the per-slot stream
// handed to the wavetable stage.
interface tdm_voice_engine_if #(
   parameter int VW     = 3,
   parameter int INC_W  = 16,
   parameter int ADDR_W = 8,
   parameter int WAVE_W = 2
) ();
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        cfg_op;
   logic [VW-1:0]     cfg_voice;
   logic [INC_W-1:0]  cfg_data;
   logic              cfg_err;
   logic [VW-1:0]     tdm_voice_num;
   logic [ADDR_W-1:0] tdm_voice_addr;
   logic [WAVE_W-1:0] tdm_wavesel;
   logic              tdm_voice_en;
   logic              tdm_frame_start;

   modport master (
      output cfg_valid, cfg_op, cfg_voice, cfg_data,
      input  cfg_ready, cfg_err,
      input  tdm_voice_num, tdm_voice_addr, tdm_wavesel, tdm_voice_en, tdm_frame_start
   );

   modport slave (
      input  cfg_valid, cfg_op, cfg_voice, cfg_data,
      output cfg_ready, cfg_err,
      output tdm_voice_num, tdm_voice_addr, tdm_wavesel, tdm_voice_en, tdm_frame_start
   );
endinterface

// File: rtl/tdm_voice_engine.sv
// Time-multiplexed NCO bank: one phase accumulator serviced per clock, round-robin,
// with a one-deep config holder whose request lands in its target voice's own slot.
module tdm_voice_engine #(
   parameter int N_VOICES            = 8,
   parameter int PHASE_W             = 24,
   parameter int INC_W               = 16,
   parameter int ADDR_W              = 8,
   parameter int WAVE_W              = 2,
   parameter bit PHASE_RESET_ON_GATE = 1'b1,
   localparam int VW                 = $clog2(N_VOICES)
) (
   input logic               sys_clk,
   input logic               sys_rst,
   tdm_voice_engine_if.slave bus
);

   typedef enum logic [1:0] {
      OP_SET_INC  = 2'd0,
      OP_SET_WAVE = 2'd1,
      OP_GATE_ON  = 2'd2,
      OP_GATE_OFF = 2'd3
   } cfg_op_e;

   localparam logic [VW:0]   N_VOICES_C  = (VW+1)'(N_VOICES);
   localparam logic [VW-1:0] LAST_SLOT_C = VW'(N_VOICES - 1);

   logic [VW-1:0]      slot_r;
   logic [PHASE_W-1:0] phase_r [N_VOICES];
   logic [INC_W-1:0]   inc_r   [N_VOICES];
   logic [WAVE_W-1:0]  wave_r  [N_VOICES];
   logic [N_VOICES-1:0] en_r;

   logic               ready_r;
   cfg_op_e            pend_op_r;
   logic [VW-1:0]      pend_voice_r;
   logic [INC_W-1:0]   pend_data_r;

   logic [VW-1:0]      num_r;
   logic [ADDR_W-1:0]  addr_r;
   logic [WAVE_W-1:0]  wavesel_r;
   logic               voice_en_r;
   logic               frame_start_r;
   logic               err_r;

   logic [PHASE_W-1:0] cur_phase_s;
   logic [PHASE_W-1:0] acc_phase_s;
   logic [PHASE_W-1:0] next_phase_s;
   logic               apply_s;
   logic               transfer_s;
   logic               voice_bad_s;

   // Phase update for the serviced slot, including any pending gate request
   always_comb begin
      cur_phase_s  = phase_r[slot_r];
      acc_phase_s  = cur_phase_s;
      next_phase_s = cur_phase_s;
      if (en_r[slot_r]) begin
         acc_phase_s = cur_phase_s + PHASE_W'(inc_r[slot_r]);
      end else begin
         acc_phase_s = cur_phase_s;
      end
      if (apply_s) begin
         case (pend_op_r)
            OP_GATE_ON: begin
               if (PHASE_RESET_ON_GATE) begin
                  next_phase_s = '0;
               end else begin
                  next_phase_s = acc_phase_s;
               end
            end
            OP_GATE_OFF: next_phase_s = cur_phase_s;
            default:     next_phase_s = acc_phase_s;
         endcase
      end else begin
         next_phase_s = acc_phase_s;
      end
   end

   // A held request waits for its own voice's slot so every store keeps one write port
   always_comb begin
      apply_s     = !ready_r && (pend_voice_r == slot_r);
      transfer_s  = bus.cfg_valid && ready_r;
      voice_bad_s = ({1'b0, bus.cfg_voice} >= N_VOICES_C);
   end

   // Slot sequencing, voice stores, config holder and registered outputs
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         slot_r <= '0;
         for (int i = 0; i < N_VOICES; i++) begin
            phase_r[i] <= '0;
            inc_r[i]   <= '0;
            wave_r[i]  <= '0;
         end
         en_r          <= '0;
         ready_r       <= 1'b1;
         pend_op_r     <= OP_SET_INC;
         pend_voice_r  <= '0;
         pend_data_r   <= '0;
         num_r         <= '0;
         addr_r        <= '0;
         wavesel_r     <= '0;
         voice_en_r    <= 1'b0;
         frame_start_r <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         if (slot_r == LAST_SLOT_C) begin
            slot_r <= '0;
         end else begin
            slot_r <= slot_r + VW'(1);
         end

         // Outputs reflect the voice state before this slot's update
         num_r           <= slot_r;
         addr_r          <= cur_phase_s[PHASE_W-1 -: ADDR_W];
         wavesel_r       <= wave_r[slot_r];
         voice_en_r      <= en_r[slot_r];
         frame_start_r   <= (slot_r == '0);
         phase_r[slot_r] <= next_phase_s;
         err_r           <= transfer_s && voice_bad_s;

         if (apply_s) begin
            ready_r <= 1'b1;
            case (pend_op_r)
               OP_SET_INC:  inc_r[slot_r]  <= pend_data_r;
               OP_SET_WAVE: wave_r[slot_r] <= pend_data_r[WAVE_W-1:0];
               OP_GATE_ON:  en_r[slot_r]   <= 1'b1;
               OP_GATE_OFF: en_r[slot_r]   <= 1'b0;
               default:     en_r           <= en_r;
            endcase
         end else if (transfer_s && !voice_bad_s) begin
            ready_r      <= 1'b0;
            pend_op_r    <= cfg_op_e'(bus.cfg_op);
            pend_voice_r <= bus.cfg_voice;
            pend_data_r  <= bus.cfg_data;
         end else begin
            ready_r <= ready_r;
         end
      end
   end

   assign bus.cfg_ready       = ready_r;
   assign bus.cfg_err         = err_r;
   assign bus.tdm_voice_num   = num_r;
   assign bus.tdm_voice_addr  = addr_r;
   assign bus.tdm_wavesel     = wavesel_r;
   assign bus.tdm_voice_en    = voice_en_r;
   assign bus.tdm_frame_start = frame_start_r;

endmodule
